// File: rtl/wbm_imem_loader.sv
// Wishbone classic initiator that streams program words into instruction SRAM.
// Words arrive on a valid/ready stream and are written to consecutive word
// addresses starting at BASE_ADDR. Each bus cycle is bounded by TIMEOUT strobe
// cycles without an acknowledge; on expiry the loader parks in an error state.
//
// Build option: define VERIFY_EN to read back every written word and compare it
// with the word just written. A mismatch is reported through err_o.

module wbm_imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  // Control
  input  logic        start_i,
  input  logic        abort_i,
  // Word stream
  input  logic        word_valid_i,
  input  logic [31:0] word_data_i,
  output logic        word_ready_o,
  // Status
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  // Wishbone initiator
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  localparam int unsigned IdxW = $clog2(DEPTH + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

`ifdef VERIFY_EN
  typedef enum logic [2:0] {StIdle, StFetch, StWrite, StVerify, StDone, StErr} state_e;
`else
  typedef enum logic [2:0] {StIdle, StFetch, StWrite, StDone, StErr} state_e;
`endif

  state_e            state_q, state_d;
  logic [IdxW-1:0]   index_q, index_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       adr_q, adr_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              abort_q, abort_d;

  logic [IdxW-1:0]   idx_inc;
  logic              last_word;
  logic              stop_req;
  logic              tmo_expired;
  state_e            adv_state;

  assign idx_inc     = index_q + IdxW'(1);
  assign last_word   = (idx_inc == IdxW'(DEPTH));
  // An abort seen at any point of the bus cycle is honoured once the word lands.
  assign stop_req    = abort_i | abort_q;
  assign tmo_expired = (tmo_q == TmoW'(TIMEOUT - 1));
  // Where to go once the current word is committed.
  assign adv_state   = last_word ? StDone : (stop_req ? StIdle : StFetch);

`ifndef VERIFY_EN
  // Read data has no consumer without read-back checking.
  logic unused_rd_data;
  assign unused_rd_data = ^wbm_dat_i;
`endif

  // State register; reset drops the bus cycle immediately.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: word index, latched word/address, timeout, abort request.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      index_q <= '0;
      word_q  <= '0;
      adr_q   <= '0;
      tmo_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      index_q <= index_d;
      word_q  <= word_d;
      adr_q   <= adr_d;
      tmo_q   <= tmo_d;
      abort_q <= abort_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    word_d  = word_q;
    adr_d   = adr_q;
    tmo_d   = tmo_q;
    abort_d = abort_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StFetch;
          index_d = '0;
        end
      end

      StFetch: begin
        abort_d = 1'b0;
        if (word_valid_i) begin
          word_d  = word_data_i;
          adr_d   = BASE_ADDR + (32'(index_q) << 2);
          tmo_d   = '0;
          state_d = StWrite;
        end else if (abort_i) begin
          state_d = StIdle;
        end
      end

      StWrite: begin
        if (abort_i) begin
          abort_d = 1'b1;
        end
        if (wbm_ack_i) begin
          tmo_d = '0;
`ifdef VERIFY_EN
          state_d = StVerify;
`else
          index_d = idx_inc;
          state_d = adv_state;
`endif
        end else if (tmo_expired) begin
          state_d = StErr;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end

`ifdef VERIFY_EN
      StVerify: begin
        if (abort_i) begin
          abort_d = 1'b1;
        end
        if (wbm_ack_i) begin
          tmo_d = '0;
          if (wbm_dat_i != word_q) begin
            state_d = StErr;
          end else begin
            index_d = idx_inc;
            state_d = adv_state;
          end
        end else if (tmo_expired) begin
          state_d = StErr;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
`endif

      StDone: begin
        if (start_i) begin
          state_d = StFetch;
          index_d = '0;
        end else begin
          state_d = StIdle;
        end
      end

      StErr: begin
        if (start_i) begin
          state_d = StFetch;
          index_d = '0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state; bus fields are zero outside a cycle.
  always_comb begin
    word_ready_o = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    wbm_cyc_o    = 1'b0;
    wbm_stb_o    = 1'b0;
    wbm_we_o     = 1'b0;
    wbm_sel_o    = 4'h0;
    wbm_adr_o    = 32'h0;
    wbm_dat_o    = 32'h0;

    unique case (state_q)
      StIdle: ;
      StFetch: begin
        word_ready_o = 1'b1;
        busy_o       = 1'b1;
      end
      StWrite: begin
        busy_o    = 1'b1;
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
        wbm_sel_o = 4'hF;
        wbm_adr_o = adr_q;
        wbm_dat_o = word_q;
      end
`ifdef VERIFY_EN
      StVerify: begin
        busy_o    = 1'b1;
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_sel_o = 4'hF;
        wbm_adr_o = adr_q;
      end
`endif
      StDone: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      StErr: begin
        err_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wbm_imem_loader.sv
// Bench for wbm_imem_loader: stream feeder, Wishbone responder with
// configurable ack latency, and a scoreboard of expected writes.
`timescale 1ns/1ps

module tb_wbm_imem_loader;

  localparam logic [31:0] Base  = 32'h3000_0000;
  localparam int unsigned Depth = 4;
  localparam int unsigned Tmo   = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        word_valid = 1'b0;
  logic [31:0] word_data = 32'h0;
  logic        word_ready, busy, done, err;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o;
  logic [31:0] dat_i = 32'h0;
  logic        ack = 1'b0;

  always #5 clk = ~clk;

  wbm_imem_loader #(
    .BASE_ADDR (Base),
    .DEPTH     (Depth),
    .TIMEOUT   (Tmo)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .start_i      (start),
    .abort_i      (abort),
    .word_valid_i (word_valid),
    .word_data_i  (word_data),
    .word_ready_o (word_ready),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .wbm_cyc_o    (cyc),
    .wbm_stb_o    (stb),
    .wbm_we_o     (we),
    .wbm_sel_o    (sel),
    .wbm_adr_o    (adr),
    .wbm_dat_o    (dat_o),
    .wbm_dat_i    (dat_i),
    .wbm_ack_i    (ack)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] sb_q[$];
  logic [31:0] src_q[$];
  logic [31:0] mem [0:3];
  bit          hs_seen = 0;
  bit          gap_en = 0;
  bit          nack = 0;
  int          ack_wait = 0;
  int          cnt = 0;
  int          writes = 0;
  int          reads = 0;
  int          done_cnt = 0;
  int          stb_cycles = 0;
  int          exp_idx = 0;
  int          corrupt_idx = -1;
  logic [31:0] adr0, dat0, last_wr_adr;
  logic [63:0] e;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Stream source: offers the head of src_q, optionally with idle gaps.
  always @(posedge clk) begin
    #1;
    if (hs_seen) begin
      hs_seen = 0;
      if (src_q.size() > 0) src_q.delete(0);
      word_valid = 1'b0;
    end
    if (src_q.size() == 0) begin
      word_valid = 1'b0;
    end else if (!word_valid && !(gap_en && $urandom_range(0, 1) == 1)) begin
      word_valid = 1'b1;
      word_data  = src_q[0];
    end
  end

  // Monitor and responder, evaluated mid-cycle so values are stable for the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      ack = 1'b0;
      cnt = 0;
    end else begin
      if (done) done_cnt++;
      if (stb) stb_cycles++;
      if (word_valid && word_ready) begin
        sb_q.push_back({Base + 32'(exp_idx * 4), word_data});
        hs_seen = 1;
      end
      if (ack) begin
        ack = 1'b0;
        cnt = 0;
      end else if (stb && !nack) begin
        if (cnt > 0) begin
          check_eq("adr_stable", adr, adr0);
          if (we) check_eq("dat_stable", dat_o, dat0);
        end else begin
          adr0 = adr;
          dat0 = dat_o;
        end
        if (cnt >= ack_wait) begin
          ack = 1'b1;
          check_eq("sel", {28'h0, sel}, 32'hF);
          if (we) begin
            check_eq("sb_avail", 32'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
              e = sb_q.pop_front();
              check_eq("wr_adr", adr, e[63:32]);
              check_eq("wr_dat", dat_o, e[31:0]);
            end
            mem[adr[3:2]] = dat_o;
            last_wr_adr = adr;
            writes++;
`ifndef VERIFY_EN
            exp_idx++;
`endif
          end else begin
            check_eq("rd_adr", adr, last_wr_adr);
            reads++;
            dat_i = (corrupt_idx == int'(adr[3:2])) ? 32'h0000_DEAD : mem[adr[3:2]];
`ifdef VERIFY_EN
            if (corrupt_idx != int'(adr[3:2])) exp_idx++;
`endif
          end
        end else begin
          cnt++;
        end
      end else if (!stb) begin
        cnt = 0;
      end
    end
  end

  function automatic bit cond(input int what, input int arg);
    case (what)
      0:       return done_cnt > 0;
      1:       return stb;
      2:       return err;
      3:       return !busy;
      4:       return (writes >= arg) && word_ready;
      default: return 1'b1;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int what, input int arg, input int budget);
    int k = 0;
    while (!cond(what, arg) && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_eq(tag, 32'(cond(what, arg)), 1);
  endtask

  task automatic start_load();
    sb_q.delete();
    exp_idx    = 0;
    stb_cycles = 0;
    writes     = 0;
    reads      = 0;
    done_cnt   = 0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic pulse_abort();
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-on reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy",  32'(busy), 0);
    check_eq("rst_cyc",   32'(cyc), 0);
    check_eq("rst_stb",   32'(stb), 0);
    check_eq("rst_ready", 32'(word_ready), 0);
    check_eq("rst_done",  32'(done), 0);
    check_eq("rst_err",   32'(err), 0);
    check_eq("rst_adr",   adr, 32'h0);
    rst_n = 1'b1;

    // Reset asserted in the middle of a stalled write
    nack = 1;
    src_q.push_back(32'hA5);
    start_load();
    wait_for("t1_stb", 1, 0, 10);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t1_cyc",   32'(cyc), 0);
    check_eq("t1_stb",   32'(stb), 0);
    check_eq("t1_done",  32'(done), 0);
    check_eq("t1_err",   32'(err), 0);
    check_eq("t1_ready", 32'(word_ready), 0);
    check_eq("t1_busy",  32'(busy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    src_q.delete();
    nack = 0;

    // Four words, ack one cycle after strobe
    ack_wait = 1;
    src_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    start_load();
    wait_for("t2_done", 0, 0, 60);
    settle();
    check_eq("t2_done_cnt", 32'(done_cnt), 1);
    check_eq("t2_writes",   32'(writes), 4);
    check_eq("t2_sb_empty", 32'(sb_q.size()), 0);
    check_eq("t2_busy",     32'(busy), 0);
    check_eq("t2_mem3",     mem[3], 32'h44);

    // Responder never acks: timeout, then recovery from index 0
    nack = 1;
    src_q.push_back(32'h55);
    start_load();
    wait_for("t3_err", 2, 0, 40);
    check_eq("t3_stb_cycles", 32'(stb_cycles), Tmo);
    check_eq("t3_err",        32'(err), 1);
    check_eq("t3_cyc",        32'(cyc), 0);
    check_eq("t3_busy",       32'(busy), 0);
    check_eq("t3_writes",     32'(writes), 0);
    settle();
    check_eq("t3_err_sticky", 32'(err), 1);
    nack = 0;
    ack_wait = 0;
    src_q = '{32'h66, 32'h77, 32'h88, 32'h99};
    start_load();
    check_eq("t3_err_clr", 32'(err), 0);
    wait_for("t3_done", 0, 0, 60);
    settle();
    check_eq("t3_done_cnt", 32'(done_cnt), 1);
    check_eq("t3_writes",   32'(writes), 4);
    check_eq("t3_mem0",     mem[0], 32'h66);

    // Stream gaps plus 3-cycle ack stalls; a start while busy is ignored
    gap_en = 1;
    ack_wait = 3;
    src_q = '{32'hA1, 32'hB2, 32'hC3, 32'hD4};
    start_load();
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_for("t4_done", 0, 0, 150);
    settle();
    check_eq("t4_done_cnt", 32'(done_cnt), 1);
    check_eq("t4_writes",   32'(writes), 4);
    check_eq("t4_sb_empty", 32'(sb_q.size()), 0);
    check_eq("t4_busy",     32'(busy), 0);
    gap_en = 0;

    // Abort while waiting for the third word
    ack_wait = 0;
    src_q = '{32'h01, 32'h02};
    start_load();
    wait_for("t5a_two", 4, 2, 40);
    pulse_abort();
    @(negedge clk);
    #1;
    check_eq("t5a_busy",   32'(busy), 0);
    check_eq("t5a_ready",  32'(word_ready), 0);
    check_eq("t5a_done",   32'(done_cnt), 0);
    check_eq("t5a_writes", 32'(writes), 2);

    // Abort during a stalled write: the write still completes
    ack_wait = 3;
    src_q = '{32'h0A, 32'h0B, 32'h0C, 32'h0D};
    start_load();
    wait_for("t5b_stb", 1, 0, 10);
    pulse_abort();
    wait_for("t5b_idle", 3, 0, 30);
    settle();
    check_eq("t5b_writes",   32'(writes), 1);
    check_eq("t5b_done",     32'(done_cnt), 0);
    check_eq("t5b_sb_empty", 32'(sb_q.size()), 0);
    check_eq("t5b_busy",     32'(busy), 0);
    src_q.delete();
    settle();

`ifdef VERIFY_EN
    // Read-back: matching data completes, corrupted word 1 errors
    ack_wait = 0;
    src_q = '{32'h1001, 32'h1002, 32'h1003, 32'h1004};
    start_load();
    wait_for("t6_done", 0, 0, 80);
    settle();
    check_eq("t6_writes", 32'(writes), 4);
    check_eq("t6_reads",  32'(reads), 4);
    check_eq("t6_done",   32'(done_cnt), 1);
    corrupt_idx = 1;
    src_q = '{32'h2001, 32'h2002, 32'h2003, 32'h2004};
    start_load();
    wait_for("t6_err", 2, 0, 80);
    check_eq("t6_err",     32'(err), 1);
    check_eq("t6_writes2", 32'(writes), 2);
    check_eq("t6_reads2",  32'(reads), 2);
    check_eq("t6_done2",   32'(done_cnt), 0);
    corrupt_idx = -1;
    src_q.delete();
    settle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
